// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM state
// encoding, frame magic byte and the word/address widths used by the
// instruction RAM write port.
package imem_loader_pkg;

  localparam int WORD_W     = 32;
  localparam int ADDR_W     = 32;
  localparam int LEN_W      = 16;
  localparam int WORD_BYTES = 4;

  localparam logic [7:0] LOADER_MAGIC = 8'hA5;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN0 = 3'd1,
    LEN1 = 3'd2,
    DATA = 3'd3,
    CSUM = 3'd4,
    DONE = 3'd5,
    ERR  = 3'd6
  } loader_state_t;

  // States that sit inside a frame and are therefore subject to the idle timeout.
  function automatic logic in_frame(input loader_state_t s);
    return (s == LEN0) || (s == LEN1) || (s == DATA) || (s == CSUM);
  endfunction

endpackage

// File: rtl/imem_loader_timeout.sv
// Idle-cycle counter for the boot loader. Counts cycles while not cleared
// and flags once TIMEOUT_CYCLES has been reached; it saturates there so a
// long stall cannot wrap back into a "not expired" value.
module loader_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expired_q, expired_d;

  // Next count: clear wins, otherwise count up and hold at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (cnt_q == LIMIT) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    expired_d = (cnt_d == LIMIT);
  end

  // Counter and registered expiry flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= expired_d;
    end
  end

  assign expired = expired_q;

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader. Parses a UART byte stream of the form
//   A5, LEN_LO, LEN_HI, N x 4 data bytes (LE words) [, CSUM]
// writes each assembled word to consecutive word addresses starting at
// BASE_ADDR, and keeps the CPU in reset until a whole image has arrived.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR
// checksum byte over LEN_LO, LEN_HI and all data bytes.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0,
  parameter int unsigned MAX_WORDS      = 4096,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        we,
  output logic [31:0] waddr,
  output logic [31:0] wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  localparam logic [31:0] MAX_WORDS_L = 32'(MAX_WORDS);

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [23:0]       word_q, word_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [LEN_W-1:0]  words_left_q, words_left_d;
  logic [7:0]        len_lo_q, len_lo_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic              magic_s;
  logic              to_clear_s;
  logic              expired_s;
  logic [LEN_W-1:0]  len_s;

  assign magic_s    = rx_valid && (rx_data == LOADER_MAGIC);
  assign to_clear_s = rx_valid || !in_frame(state_q);
  assign len_s      = {rx_data, len_lo_q};

  loader_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (to_clear_s),
    .expired (expired_s)
  );

  // Frame parser: next state, word assembly, write strobe and status flags.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    we_d         = 1'b0;
    cpu_hold_d   = cpu_hold_q;
    done_d       = done_q;
    error_d      = error_q;
    word_d       = word_q;
    byte_idx_d   = byte_idx_q;
    words_left_d = words_left_q;
    len_lo_d     = len_lo_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d       = csum_q;
`endif

    case (state_q)
      IDLE, DONE, ERR: begin
        if (magic_s) begin
          state_d    = LEN0;
          done_d     = 1'b0;
          error_d    = 1'b0;
          cpu_hold_d = 1'b1;
          addr_d     = BASE_ADDR;
          byte_idx_d = 2'd0;
          word_d     = 24'h0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d     = 8'h00;
`endif
        end else begin
          state_d = state_q;
        end
      end

      LEN0: begin
        if (rx_valid) begin
          len_lo_d = rx_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d   = csum_q ^ rx_data;
`endif
          state_d  = LEN1;
        end else if (expired_s) begin
          state_d    = ERR;
          error_d    = 1'b1;
          cpu_hold_d = 1'b1;
        end else begin
          state_d = state_q;
        end
      end

      LEN1: begin
        if (rx_valid) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ rx_data;
`endif
          if ({16'h0, len_s} > MAX_WORDS_L) begin
            state_d    = ERR;
            error_d    = 1'b1;
            cpu_hold_d = 1'b1;
          end else if (len_s == 16'h0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d    = CSUM;
`else
            state_d    = DONE;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
`endif
          end else begin
            words_left_d = len_s;
            state_d      = DATA;
          end
        end else if (expired_s) begin
          state_d    = ERR;
          error_d    = 1'b1;
          cpu_hold_d = 1'b1;
        end else begin
          state_d = state_q;
        end
      end

      DATA: begin
        if (rx_valid) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ rx_data;
`endif
          case (byte_idx_q)
            2'd0: begin
              word_d[7:0] = rx_data;
              byte_idx_d  = 2'd1;
            end
            2'd1: begin
              word_d[15:8] = rx_data;
              byte_idx_d   = 2'd2;
            end
            2'd2: begin
              word_d[23:16] = rx_data;
              byte_idx_d    = 2'd3;
            end
            default: begin
              we_d         = 1'b1;
              waddr_d      = addr_q;
              wdata_d      = {rx_data, word_q};
              addr_d       = addr_q + 32'd4;
              byte_idx_d   = 2'd0;
              words_left_d = words_left_q - 16'd1;
              if (words_left_q == 16'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state_d    = CSUM;
`else
                state_d    = DONE;
                done_d     = 1'b1;
                cpu_hold_d = 1'b0;
`endif
              end else begin
                state_d = DATA;
              end
            end
          endcase
        end else if (expired_s) begin
          state_d    = ERR;
          error_d    = 1'b1;
          cpu_hold_d = 1'b1;
        end else begin
          state_d = state_q;
        end
      end

      CSUM: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (rx_valid) begin
          if (rx_data == csum_q) begin
            state_d    = DONE;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end else begin
            state_d    = ERR;
            error_d    = 1'b1;
            cpu_hold_d = 1'b1;
          end
        end else if (expired_s) begin
          state_d    = ERR;
          error_d    = 1'b1;
          cpu_hold_d = 1'b1;
        end else begin
          state_d = state_q;
        end
`else
        // Unreachable without a checksum byte; fail safe.
        state_d    = ERR;
        error_d    = 1'b1;
        cpu_hold_d = 1'b1;
`endif
      end

      default: begin
        state_d    = ERR;
        error_d    = 1'b1;
        cpu_hold_d = 1'b1;
      end
    endcase
  end

  // All loader state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= BASE_ADDR;
      waddr_q      <= BASE_ADDR;
      wdata_q      <= 32'h0;
      we_q         <= 1'b0;
      cpu_hold_q   <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      word_q       <= 24'h0;
      byte_idx_q   <= 2'd0;
      words_left_q <= 16'h0;
      len_lo_q     <= 8'h00;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q       <= 8'h00;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      cpu_hold_q   <= cpu_hold_d;
      done_q       <= done_d;
      error_q      <= error_d;
      word_q       <= word_d;
      byte_idx_q   <= byte_idx_d;
      words_left_q <= words_left_d;
      len_lo_q     <= len_lo_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign we       = we_q;
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;
  assign cpu_hold = cpu_hold_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a per-byte vector table for whole frames
// plus hand-written sequences for timeout, idling in DONE and mid-frame reset.
// Builds with or without IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;

  localparam int TO = 40;
  localparam logic [31:0] W0 = 32'hFE010113;
  localparam logic [31:0] W1 = 32'h00812E23;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  imem_loader #(
    .BASE_ADDR      (32'h0),
    .MAX_WORDS      (4096),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        w;
    logic [31:0] wa;
    logic [31:0] wd;
    logic        h;
    logic        dn;
    logic        er;
  } vec_t;

  vec_t vecs[$];
  int   tests  = 0;
  int   failed = 0;
  int   we_cnt = 0;
  int   we_base;
  int   k;

  always @(posedge clk) begin
    if (we === 1'b1) we_cnt <= we_cnt + 1;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [7:0] d, input logic w, input logic [31:0] wa,
                     input logic [31:0] wd, input logic h, input logic dn, input logic er);
    vec_t t;
    t.v = v; t.d = d; t.w = w; t.wa = wa; t.wd = wd; t.h = h; t.dn = dn; t.er = er;
    vecs.push_back(t);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_we"},    {127'h0, we},       {127'h0, 1'b0});
    chk({name, "_waddr"}, {96'h0, waddr},     128'h0);
    chk({name, "_wdata"}, {96'h0, wdata},     128'h0);
    chk({name, "_hold"},  {127'h0, cpu_hold}, {127'h0, 1'b1});
    chk({name, "_done"},  {127'h0, done},     {127'h0, 1'b0});
    chk({name, "_error"}, {127'h0, error},    {127'h0, 1'b0});
  endtask

  // Watchdog: the run is a few thousand cycles at most.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    @(negedge clk);
    rst = 1'b0;

    // ---- vector table: one entry per cycle, outputs checked after the edge ----
    // junk before magic is ignored
    add(1, 8'h00, 0, 32'h0, 32'h0, 1, 0, 0);
    add(1, 8'hFF, 0, 32'h0, 32'h0, 1, 0, 0);
    add(1, 8'h5A, 0, 32'h0, 32'h0, 1, 0, 0);
    add(0, 8'h00, 0, 32'h0, 32'h0, 1, 0, 0);
    // empty image
    add(1, 8'hA5, 0, 32'h0, 32'h0, 1, 0, 0);
    add(1, 8'h00, 0, 32'h0, 32'h0, 1, 0, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    add(1, 8'h00, 0, 32'h0, 32'h0, 1, 0, 0);
    add(1, 8'h00, 0, 32'h0, 32'h0, 0, 1, 0);
`else
    add(1, 8'h00, 0, 32'h0, 32'h0, 0, 1, 0);
`endif
    // two-word image, started from DONE
    add(1, 8'hA5, 0, 32'h0, 32'h0, 1, 0, 0);
    add(1, 8'h02, 0, 32'h0, 32'h0, 1, 0, 0);
    add(1, 8'h00, 0, 32'h0, 32'h0, 1, 0, 0);
    add(1, 8'h13, 0, 32'h0, 32'h0, 1, 0, 0);
    add(1, 8'h01, 0, 32'h0, 32'h0, 1, 0, 0);
    add(1, 8'h01, 0, 32'h0, 32'h0, 1, 0, 0);
    add(1, 8'hFE, 1, 32'h0, W0,    1, 0, 0);
    add(1, 8'h23, 0, 32'h0, W0,    1, 0, 0);
    add(1, 8'h2E, 0, 32'h0, W0,    1, 0, 0);
    add(1, 8'h81, 0, 32'h0, W0,    1, 0, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    add(1, 8'h00, 1, 32'h4, W1,    1, 0, 0);
    add(1, 8'h63, 0, 32'h4, W1,    0, 1, 0);
`else
    add(1, 8'h00, 1, 32'h4, W1,    0, 1, 0);
`endif
    add(0, 8'h00, 0, 32'h4, W1,    0, 1, 0);
    // same image again; with checksum the trailing byte is wrong, without it is junk in DONE
    add(1, 8'hA5, 0, 32'h4, W1,    1, 0, 0);
    add(1, 8'h02, 0, 32'h4, W1,    1, 0, 0);
    add(1, 8'h00, 0, 32'h4, W1,    1, 0, 0);
    add(1, 8'h13, 0, 32'h4, W1,    1, 0, 0);
    add(1, 8'h01, 0, 32'h4, W1,    1, 0, 0);
    add(1, 8'h01, 0, 32'h4, W1,    1, 0, 0);
    add(1, 8'hFE, 1, 32'h0, W0,    1, 0, 0);
    add(1, 8'h23, 0, 32'h0, W0,    1, 0, 0);
    add(1, 8'h2E, 0, 32'h0, W0,    1, 0, 0);
    add(1, 8'h81, 0, 32'h0, W0,    1, 0, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    add(1, 8'h00, 1, 32'h4, W1,    1, 0, 0);
    add(1, 8'h62, 0, 32'h4, W1,    1, 0, 1);
`else
    add(1, 8'h00, 1, 32'h4, W1,    0, 1, 0);
    add(1, 8'h62, 0, 32'h4, W1,    0, 1, 0);
`endif
    // oversized length 4097 rejected at LEN_HI, following bytes ignored
    add(1, 8'hA5, 0, 32'h4, W1,    1, 0, 0);
    add(1, 8'h01, 0, 32'h4, W1,    1, 0, 0);
    add(1, 8'h10, 0, 32'h4, W1,    1, 0, 1);
    add(1, 8'h13, 0, 32'h4, W1,    1, 0, 1);
    // recovery from ERR with a valid empty image
    add(1, 8'hA5, 0, 32'h4, W1,    1, 0, 0);
    add(1, 8'h00, 0, 32'h4, W1,    1, 0, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    add(1, 8'h00, 0, 32'h4, W1,    1, 0, 0);
    add(1, 8'h00, 0, 32'h4, W1,    0, 1, 0);
`else
    add(1, 8'h00, 0, 32'h4, W1,    0, 1, 0);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rx_valid = vecs[i].v;
      rx_data  = vecs[i].d;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i),
          {61'h0, we, waddr, wdata, cpu_hold, done, error},
          {61'h0, vecs[i].w, vecs[i].wa, vecs[i].wd, vecs[i].h, vecs[i].dn, vecs[i].er});
    end
    @(negedge clk);
    rx_valid = 1'b0;

    // ---- timeout inside DATA; a byte restarts the idle window ----
    we_base = we_cnt;
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h13);
    send_byte(8'h01);
    idle(TO - 2);
    chk("to_early1", {127'h0, error}, {127'h0, 1'b0});
    send_byte(8'h01);
    idle(TO - 2);
    chk("to_early2", {127'h0, error}, {127'h0, 1'b0});
    k = 0;
    while (error !== 1'b1 && k < TO + 5) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("to_error", {127'h0, error}, {127'h0, 1'b1});
    chk("to_hold",  {127'h0, cpu_hold}, {127'h0, 1'b1});
    chk("to_nowrite", 128'(we_cnt - we_base), 128'h0);

    // ---- long idle in DONE never raises error ----
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h00);
`endif
    chk("done_set", {125'h0, cpu_hold, done, error}, {125'h0, 3'b010});
    idle(2 * TO + 5);
    chk("done_idle", {125'h0, cpu_hold, done, error}, {125'h0, 3'b010});

    // ---- reset mid-DATA, then bytes without magic, then a full frame ----
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h13);
    send_byte(8'h01);
    rst = 1'b1;
    #1;
    chk_reset_vals("midrst");
    @(negedge clk);
    rst = 1'b0;
    we_base = we_cnt;
    send_byte(8'h01);
    send_byte(8'hFE);
    idle(1);
    chk("nomagic", {126'h0, we, cpu_hold}, {126'h0, 2'b01});
    chk("nomagic_cnt", 128'(we_cnt - we_base), 128'h0);
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h13);
    send_byte(8'h01);
    send_byte(8'h01);
    send_byte(8'hFE);
    chk("rw0", {63'h0, we, waddr, wdata}, {63'h0, 1'b1, 32'h0, W0});
    send_byte(8'h23);
    send_byte(8'h2E);
    send_byte(8'h81);
    send_byte(8'h00);
    chk("rw1", {63'h0, we, waddr, wdata}, {63'h0, 1'b1, 32'h4, W1});
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h63);
`endif
    chk("rdone", {125'h0, cpu_hold, done, error}, {125'h0, 3'b010});

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
